// File: rtl/fc_grad_engine.sv
// Output-layer gradient engine: turns (logit, label) pairs into per-output scaled errors,
// then streams bias updates followed by one weight update per (activation, output) pair.
module fc_grad_engine #(
  parameter int N_IN  = 196,
  parameter int N_OUT = 10,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  localparam int RW = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int CW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] lr,
  output logic          busy,
  output logic          done,
  input  logic          err_valid,
  output logic          err_ready,
  input  logic [DW-1:0] logit,
  input  logic [DW-1:0] label,
  input  logic          act_valid,
  output logic          act_ready,
  input  logic [DW-1:0] act,
  output logic          upd_valid,
  input  logic          upd_ready,
  output logic [DW-1:0] upd_data,
  output logic          upd_is_bias,
  output logic [RW-1:0] upd_row,
  output logic [CW-1:0] upd_col
);

  typedef enum logic [2:0] {IDLE, LOAD, BIAS, WEIGHT, DONE} state_t;

  localparam logic signed [2*DW-1:0] RND    = (2*DW)'(1) << (FRAC - 1);
  localparam logic signed [2*DW-1:0] SAT_HI = {{DW{1'b0}}, 1'b0, {(DW-1){1'b1}}};
  localparam logic signed [2*DW-1:0] SAT_LO = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_t                state_reg, state_next;
  logic signed [DW-1:0]  lr_reg, lr_next;
  logic signed [DW-1:0]  act_reg, act_next;
  logic                  act_held_reg, act_held_next;
  logic [CW-1:0]         col_reg, col_next;
  logic [RW-1:0]         row_reg, row_next;
  logic signed [DW-1:0]  s_reg [N_OUT];

  logic signed [DW:0]    diff;
  logic signed [DW-1:0]  err_sat;
  logic signed [DW-1:0]  s_new;
  logic signed [DW-1:0]  w_data;
  logic                  last_col, last_row;

  // Round half up in the full-width product, then clamp back into DW bits.
  function automatic logic signed [DW-1:0] sat_rnd(input logic signed [2*DW-1:0] p);
    logic signed [2*DW-1:0] r;
    r = (p + RND) >>> FRAC;
    if (r > SAT_HI)
      sat_rnd = SAT_HI[DW-1:0];
    else if (r < SAT_LO)
      sat_rnd = SAT_LO[DW-1:0];
    else
      sat_rnd = r[DW-1:0];
  endfunction

  assign diff    = {logit[DW-1], logit} - {label[DW-1], label};
  assign err_sat = (diff[DW] != diff[DW-1]) ?
                   (diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}}) :
                   diff[DW-1:0];
  assign s_new   = sat_rnd((2*DW)'(lr_reg) * (2*DW)'(err_sat));
  assign w_data  = sat_rnd((2*DW)'(s_reg[col_reg]) * (2*DW)'(act_reg));
  assign last_col = (col_reg == CW'(N_OUT - 1));
  assign last_row = (row_reg == RW'(N_IN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      lr_reg       <= '0;
      act_reg      <= '0;
      act_held_reg <= 1'b0;
      col_reg      <= '0;
      row_reg      <= '0;
      for (int i = 0; i < N_OUT; i++) s_reg[i] <= '0;
    end else begin
      state_reg    <= state_next;
      lr_reg       <= lr_next;
      act_reg      <= act_next;
      act_held_reg <= act_held_next;
      col_reg      <= col_next;
      row_reg      <= row_next;
      if (state_reg == LOAD && err_valid) s_reg[col_reg] <= s_new;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lr_next       = lr_reg;
    act_next      = act_reg;
    act_held_next = act_held_reg;
    col_next      = col_reg;
    row_next      = row_reg;
    busy          = (state_reg != IDLE);
    done          = 1'b0;
    err_ready     = 1'b0;
    act_ready     = 1'b0;
    upd_valid     = 1'b0;
    upd_data      = '0;
    upd_is_bias   = 1'b0;
    upd_row       = '0;
    upd_col       = '0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = LOAD;
          lr_next       = lr;
          col_next      = '0;
          row_next      = '0;
          act_held_next = 1'b0;
        end
      end
      LOAD: begin
        err_ready = 1'b1;
        if (err_valid) begin
          if (last_col) begin
            col_next   = '0;
            state_next = BIAS;
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end
      BIAS: begin
        upd_valid   = 1'b1;
        upd_is_bias = 1'b1;
        upd_col     = col_reg;
        upd_data    = s_reg[col_reg];
        if (upd_ready) begin
          if (last_col) begin
            col_next   = '0;
            state_next = WEIGHT;
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end
      WEIGHT: begin
        // One activation is held at a time; it is replaced only after its last column drains.
        act_ready = !act_held_reg;
        upd_valid = act_held_reg;
        upd_row   = row_reg;
        upd_col   = col_reg;
        upd_data  = act_held_reg ? w_data : '0;
        if (!act_held_reg && act_valid) begin
          act_held_next = 1'b1;
          act_next      = act;
        end
        if (act_held_reg && upd_ready) begin
          if (last_col) begin
            col_next      = '0;
            act_held_next = 1'b0;
            if (last_row) begin
              row_next   = '0;
              state_next = DONE;
            end else begin
              row_next = row_reg + 1'b1;
            end
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fc_grad_engine.sv
// Randomized bench for fc_grad_engine: an arithmetic model predicts every update in order,
// and a per-cycle monitor checks handshakes, hold stability and the done pulse.
module tb_fc_grad_engine;
  localparam int N_IN = 4, N_OUT = 3, DW = 16, FRAC = 8;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [DW-1:0] lr = '0, logit = '0, label = '0, act = '0;
  logic          err_valid = 1'b0, act_valid = 1'b0, upd_ready;
  logic          busy, done, err_ready, act_ready, upd_valid, upd_is_bias;
  logic [DW-1:0] upd_data;
  logic [1:0]    upd_row, upd_col;

  fc_grad_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start), .lr(lr), .busy(busy), .done(done),
    .err_valid(err_valid), .err_ready(err_ready), .logit(logit), .label(label),
    .act_valid(act_valid), .act_ready(act_ready), .act(act),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_data(upd_data),
    .upd_is_bias(upd_is_bias), .upd_row(upd_row), .upd_col(upd_col)
  );

  always #5 clk = ~clk;

  int          total = 0, bad = 0, done_cnt = 0, cyc = 0;
  int          bp_at = -100;
  bit          rand_ready = 1'b0;
  logic [20:0] exp_q[$];
  logic [20:0] cur, prev_upd, exp_item;
  bit          prev_stall = 1'b0;
  logic [15:0] last_bias = '0, last_w = '0;
  logic [15:0] lg_a[N_OUT], lb_a[N_OUT], ac_a[N_IN];

  // upd_ready: random or always high, with an optional 5-cycle forced-low window.
  initial begin
    upd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      upd_ready = !(cyc >= bp_at && cyc < bp_at + 5) && (!rand_ready || ($urandom_range(0, 3) != 0));
    end
  end

  function automatic int sat_m(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int mul_q(int a, int b);
    longint p;
    p = longint'(a) * longint'(b) + longint'(1 << (FRAC - 1));
    return sat_m(p >>> FRAC);
  endfunction

  function automatic int sx(logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [20:0] pack(logic b, int r, int c, int d);
    return {b, 2'(r), 2'(c), 16'(d)};
  endfunction

  task automatic build_expected(input logic [15:0] lr_v);
    int s[N_OUT];
    for (int i = 0; i < N_OUT; i++) begin
      s[i] = mul_q(sx(lr_v), sat_m(longint'(sx(lg_a[i])) - longint'(sx(lb_a[i]))));
      exp_q.push_back(pack(1'b1, 0, i, s[i]));
    end
    for (int j = 0; j < N_IN; j++)
      for (int i = 0; i < N_OUT; i++)
        exp_q.push_back(pack(1'b0, j, i, mul_q(s[i], sx(ac_a[j]))));
  endtask

  task automatic wait_ready(input bit is_act);
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      seen = is_act ? act_ready : err_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL handshake_timeout %s: ready stayed 0 for %0d cycles, want 1", is_act ? "act" : "err", n);
    end
  endtask

  task automatic check_zero(input string tag);
    total++;
    if ({busy, done, upd_valid, err_ready, act_ready, upd_is_bias, upd_row, upd_col, upd_data} !== '0) begin
      bad++;
      $display("FAIL %s: busy=%b done=%b uv=%b er=%b ar=%b bias=%b row=%0d col=%0d data=%h, want all 0",
               tag, busy, done, upd_valid, err_ready, act_ready, upd_is_bias, upd_row, upd_col, upd_data);
    end
  endtask

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic run_sample(input logic [15:0] lr_v, input int abort_row, input bit do_bp, input bit busy_start);
    int d0, n;
    build_expected(lr_v);
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; lr = lr_v;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total++;
    if (!(err_ready && busy)) begin
      bad++;
      $display("FAIL first_err_ready: err_ready=%b busy=%b, want 1 1", err_ready, busy);
    end
    @(posedge clk); #1;
    for (int i = 0; i < N_OUT; i++) begin
      err_valid = 1'b1; logit = lg_a[i]; label = lb_a[i];
      wait_ready(1'b0);
    end
    err_valid = 1'b0;
    act_valid = 1'b1; act = ac_a[0];
    if (busy_start) begin
      start = 1'b1; lr = 16'h7FFF;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int j = 0; j < N_IN; j++) begin
      act_valid = 1'b1; act = ac_a[j];
      wait_ready(1'b1);
      if (do_bp && j == 1) bp_at = cyc + 2;
      if (j == abort_row) begin
        act_valid = 1'b0;
        rst = 1'b0;
        #1 check_zero("reset_mid_weight");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        return;
      end
      act_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    act_valid = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 200) begin @(posedge clk); #1; n++; end
    repeat (2) begin @(posedge clk); #1; end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL done_pulses: got %0d want 1", done_cnt - d0);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_updates: %0d expected updates never seen, want 0", exp_q.size());
    end
    exp_q.delete();
    @(negedge clk);
    total++;
    if (busy) begin
      bad++;
      $display("FAIL busy_after_done: got 1 want 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic set_nominal();
    for (int i = 0; i < N_OUT; i++) begin lg_a[i] = 16'h0200; lb_a[i] = 16'h0100; end
    for (int j = 0; j < N_IN; j++) ac_a[j] = 16'h0200;
  endtask

  initial begin
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (!rst) begin
            prev_stall = 1'b0;
          end else begin
            cur = {upd_is_bias, upd_row, upd_col, upd_data};
            if (prev_stall) begin
              total++;
              if (!upd_valid || cur !== prev_upd) begin
                bad++;
                $display("FAIL hold_stable: valid=%b upd=%h, want valid=1 upd=%h", upd_valid, cur, prev_upd);
              end
            end
            if (upd_valid && !upd_is_bias) begin
              total++;
              if (act_ready) begin
                bad++;
                $display("FAIL act_ready_while_held: got 1 want 0");
              end
            end
            if (upd_valid && upd_ready) begin
              total++;
              $display("upd bias=%0b row=%0d col=%0d data=%h", upd_is_bias, upd_row, upd_col, upd_data);
              if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL extra_update: got %h, want no update", cur);
              end else begin
                exp_item = exp_q.pop_front();
                if (cur !== exp_item) begin
                  bad++;
                  $display("FAIL update: got bias=%b row=%0d col=%0d data=%h want bias=%b row=%0d col=%0d data=%h",
                           cur[20], cur[19:18], cur[17:16], cur[15:0],
                           exp_item[20], exp_item[19:18], exp_item[17:16], exp_item[15:0]);
                end
              end
              if (upd_is_bias) last_bias = upd_data; else last_w = upd_data;
            end
            if (done) done_cnt++;
            prev_stall = upd_valid && !upd_ready;
            prev_upd = cur;
          end
        end
      end
      begin : stimulus
        repeat (3) @(posedge clk);
        #1 check_zero("reset_state");
        rst = 1'b1;
        // Handshake inputs must be ignored in IDLE.
        err_valid = 1'b1; act_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (err_ready || act_ready || busy) begin
          bad++;
          $display("FAIL idle_ignore: err_ready=%b act_ready=%b busy=%b want 0 0 0", err_ready, act_ready, busy);
        end
        err_valid = 1'b0; act_valid = 1'b0;
        @(posedge clk); #1;

        set_nominal();
        run_sample(16'h0080, -1, 1'b0, 1'b0);
        check_val("nominal_bias", last_bias, 16'h0080);
        check_val("nominal_weight", last_w, 16'h0100);

        for (int i = 0; i < N_OUT; i++) begin lg_a[i] = 16'h7F00; lb_a[i] = 16'h8000; end
        for (int j = 0; j < N_IN; j++) ac_a[j] = 16'h7FFF;
        run_sample(16'h0100, -1, 1'b0, 1'b0);
        check_val("sat_bias", last_bias, 16'h7FFF);
        check_val("sat_weight", last_w, 16'h7FFF);

        for (int i = 0; i < N_OUT; i++) begin lg_a[i] = 16'h0101; lb_a[i] = 16'h0100; end
        for (int j = 0; j < N_IN; j++) ac_a[j] = 16'h0080;
        run_sample(16'h0100, -1, 1'b0, 1'b0);
        check_val("round_bias", last_bias, 16'h0001);
        check_val("round_weight", last_w, 16'h0001);

        set_nominal();
        run_sample(16'h0080, -1, 1'b1, 1'b0);
        check_val("backpressure_weight", last_w, 16'h0100);

        run_sample(16'h0080, 2, 1'b0, 1'b0);
        @(negedge clk);
        check_zero("after_reset_release");
        @(posedge clk); #1;
        run_sample(16'h0080, -1, 1'b0, 1'b0);
        check_val("restart_weight", last_w, 16'h0100);

        run_sample(16'h0080, -1, 1'b0, 1'b1);
        check_val("busy_start_bias", last_bias, 16'h0080);
        check_val("busy_start_weight", last_w, 16'h0100);

        rand_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
          for (int i = 0; i < N_OUT; i++) begin
            lg_a[i] = 16'($urandom);
            lb_a[i] = (t % 2 == 0) ? 16'($urandom_range(0, 1) << 8) : 16'($urandom);
          end
          for (int j = 0; j < N_IN; j++) ac_a[j] = 16'($urandom);
          run_sample((t < 4) ? 16'($urandom_range(0, 16'h0200)) : 16'($urandom), -1, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join_any
  end

endmodule
